// File: rtl/softmax_pkg.sv
// Shared sizing constants and stream-state encoding for the softmax datapath
// and its output-side helpers.
package softmax_pkg;

    localparam int SM_N       = 10;
    localparam int SM_W       = 16;
    localparam int SM_IDX_W   = 4;
    localparam int SM_LATENCY = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } sm_state_t;

endpackage

// File: rtl/softmax_valid_delay.sv
// Tracks the softmax pipeline latency: a LATENCY-deep valid shift register
// with synchronous clear, so the tap marks the cycle the matching results exist.
module softmax_valid_delay #(
    parameter int LATENCY = 4
) (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_vld,
    output logic o_vld
);

    logic [LATENCY-1:0] r_vld_p;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_vld_p <= '0;
        end else begin
            r_vld_p[0] <= i_vld;
            for (int k = 1; k < LATENCY; k++) begin
                r_vld_p[k] <= r_vld_p[k-1];
            end
        end
    end

    assign o_vld = r_vld_p[LATENCY-1];

endmodule

// File: rtl/softmax_result_streamer.sv
// Captures the parallel softmax result vector into one buffer, streams it as
// N AXI-Stream beats with backpressure, and reports the argmax after the last beat.
module softmax_result_streamer
    import softmax_pkg::*;
#(
    parameter int N       = SM_N,
    parameter int W       = SM_W,
    parameter int LATENCY = SM_LATENCY,
    parameter int IDX_W   = SM_IDX_W
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             x_valid,
    input  logic [N*W-1:0]   result_vec,
    output logic [W-1:0]     m_tdata,
    output logic [IDX_W-1:0] m_tuser,
    output logic             m_tlast,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [IDX_W-1:0] argmax,
    output logic             argmax_valid,
    output logic             busy,
    output logic             overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    sm_state_t        r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [W-1:0]     r_buf [N];
    logic [W-1:0]     r_max;
    logic [IDX_W-1:0] r_max_idx;
    logic [IDX_W-1:0] r_argmax;
    logic             r_argmax_vld;
    logic             r_overrun;

    logic             w_tap;
    logic             w_send;
    logic             w_hs;
    logic             w_last;
    logic             w_free;
    logic             w_cap;
    logic [W-1:0]     w_beat;
    logic             w_upd;
    logic [IDX_W-1:0] w_run_idx;

    softmax_valid_delay #(
        .LATENCY (LATENCY)
    ) u_vld_delay (
        .i_clk (aclk),
        .i_clr (areset),
        .i_vld (x_valid),
        .o_vld (w_tap)
    );

    assign w_send = (r_state == ST_SEND);
    assign w_hs   = w_send && m_tready;
    assign w_last = (r_idx == LAST_IDX);
    // Accepting the final beat frees the buffer in the same cycle, so vectors
    // can stream back-to-back without a bubble.
    assign w_free = !w_send || (w_hs && w_last);
    assign w_cap  = w_tap && w_free;

    assign w_beat    = r_buf[r_idx];
    assign w_upd     = (r_idx == '0) || (w_beat > r_max);
    assign w_run_idx = w_upd ? r_idx : r_max_idx;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (w_cap) begin
                    w_state_nxt = ST_SEND;
                    w_idx_nxt   = '0;
                end
            end
            ST_SEND: begin
                if (w_hs) begin
                    if (w_last) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = w_cap ? ST_SEND : ST_IDLE;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_argmax     <= '0;
            r_argmax_vld <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_argmax_vld <= w_hs && w_last;
            if (w_hs && w_last) begin
                r_argmax <= w_run_idx;
            end
            if (w_tap && !w_free) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Data storage carries no reset; outputs are gated by state instead.
    always_ff @(posedge aclk) begin
        if (w_cap) begin
            for (int i = 0; i < N; i++) begin
                r_buf[i] <= result_vec[i*W +: W];
            end
        end
        if (w_hs) begin
            if (w_upd) begin
                r_max <= w_beat;
            end
            r_max_idx <= w_run_idx;
        end
    end

    assign m_tvalid     = w_send;
    assign m_tdata      = w_send ? w_beat : '0;
    assign m_tuser      = w_send ? r_idx : '0;
    assign m_tlast      = w_send && w_last;
    assign busy         = w_send;
    assign argmax       = r_argmax;
    assign argmax_valid = r_argmax_vld;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_softmax_result_streamer.sv
// Self-checking bench: vector-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_softmax_result_streamer;
    import softmax_pkg::*;

    localparam int N   = SM_N;
    localparam int W   = SM_W;
    localparam int IW  = SM_IDX_W;
    localparam int LAT = SM_LATENCY;

    logic            aclk = 1'b0;
    logic            areset = 1'b1;
    logic            x_valid = 1'b0;
    logic            m_tready = 1'b0;
    logic [N*W-1:0]  result_vec = '0;
    logic [W-1:0]    m_tdata;
    logic [IW-1:0]   m_tuser;
    logic            m_tlast;
    logic            m_tvalid;
    logic [IW-1:0]   argmax;
    logic            argmax_valid;
    logic            busy;
    logic            overrun;

    softmax_result_streamer dut (
        .aclk         (aclk),
        .areset       (areset),
        .x_valid      (x_valid),
        .result_vec   (result_vec),
        .m_tdata      (m_tdata),
        .m_tuser      (m_tuser),
        .m_tlast      (m_tlast),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .argmax       (argmax),
        .argmax_valid (argmax_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int rdy_mode = 0;
    logic [N*W-1:0] sched [int];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] rand_vec(input int maxv);
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom_range(0, maxv));
        return v;
    endfunction

    function automatic int first_max(input logic [W-1:0] v [N]);
        int bi = 0;
        for (int i = 1; i < N; i++) if (v[i] > v[bi]) bi = i;
        return bi;
    endfunction

    // Reference model: one pending vector with a count of beats still owed.
    logic [W-1:0] mv [N];
    int mrem = 0, mam = 0, mamv = 0, movr = 0, mcap_am = 0;
    int q[$];
    int pos;
    bit tap;

    always @(negedge aclk) begin
        pos = N - mrem;
        chk("m_tvalid", m_tvalid, mrem > 0);
        chk("busy", busy, mrem > 0);
        chk("m_tdata", m_tdata, (mrem > 0) ? mv[pos] : 0);
        chk("m_tuser", m_tuser, (mrem > 0) ? pos : 0);
        chk("m_tlast", m_tlast, mrem == 1);
        chk("argmax", argmax, mam);
        chk("argmax_valid", argmax_valid, mamv);
        chk("overrun", overrun, movr);
        if (areset) begin
            mrem = 0; mam = 0; mamv = 0; movr = 0;
            q.delete();
        end else begin
            tap = (q.size() > 0) && (q[0] == cyc + 1);
            if (tap) void'(q.pop_front());
            mamv = 0;
            if (mrem > 0 && m_tready) begin
                mrem--;
                if (mrem == 0) begin
                    mam  = mcap_am;
                    mamv = 1;
                end
            end
            if (tap) begin
                if (mrem == 0) begin
                    for (int i = 0; i < N; i++) mv[i] = result_vec[i*W +: W];
                    mcap_am = first_max(mv);
                    mrem    = N;
                end else begin
                    movr = 1;
                end
            end
            if (x_valid) q.push_back(cyc + 1 + LAT);
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
        x_valid = 1'b0;
        if (sched.exists(cyc + 1)) result_vec = sched[cyc + 1];
        else result_vec = rand_vec(65535);
        case (rdy_mode)
            0: m_tready = 1'b1;
            1: m_tready = ~m_tready;
            2: m_tready = 1'($urandom_range(0, 1));
            default: m_tready = 1'b0;
        endcase
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic issue(input logic [N*W-1:0] v);
        x_valid = 1'b1;
        sched[cyc + 1 + LAT] = v;
    endtask

    logic [N*W-1:0] v;
    int c0;

    initial begin
        // reset state
        steps(3);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_argmax", argmax, 0);
        areset = 1'b0;
        steps(2);

        // single vector, always ready
        for (int i = 0; i < N; i++) v[i*W +: W] = W'(100 * (i + 1));
        step(); c0 = cyc; issue(v);
        steps(4);
        chk("t1_c4_tvalid", m_tvalid, 0);
        step();
        chk("t1_c5_tvalid", m_tvalid, 1);
        chk("t1_c5_tuser", m_tuser, 0);
        chk("t1_c5_tdata", m_tdata, 100);
        steps(9);
        chk("t1_c14_tlast", m_tlast, 1);
        chk("t1_c14_tuser", m_tuser, 9);
        chk("t1_c14_tdata", m_tdata, 1000);
        step();
        chk("t1_c15_argmax_valid", argmax_valid, 1);
        chk("t1_c15_argmax", argmax, 9);
        chk("t1_c15_tvalid", m_tvalid, 0);
        chk("t1_overrun", overrun, 0);
        steps(3);

        // backpressure, ready toggling
        rdy_mode = 1;
        step(); issue(rand_vec(65535));
        steps(32);
        rdy_mode = 0;
        steps(3);

        // back-to-back vectors
        for (int i = 0; i < N; i++) v[i*W +: W] = W'(7 + i);
        step(); c0 = cyc; issue(rand_vec(65535));
        steps(10); issue(v);
        steps(4);
        chk("b2b_c14_tlast", m_tlast, 1);
        step();
        chk("b2b_c15_tvalid", m_tvalid, 1);
        chk("b2b_c15_tuser", m_tuser, 0);
        chk("b2b_c15_tdata", m_tdata, 7);
        chk("b2b_overrun", overrun, 0);
        steps(14);

        // overrun: second vector while buffer held
        rdy_mode = 3;
        step(); issue(rand_vec(65535));
        steps(2); issue(rand_vec(65535));
        steps(8);
        chk("ovr_set", overrun, 1);
        chk("ovr_held_tuser", m_tuser, 0);
        rdy_mode = 0;
        steps(14);
        chk("ovr_sticky", overrun, 1);
        areset = 1'b1; steps(2); areset = 1'b0;
        chk("ovr_cleared", overrun, 0);
        steps(2);

        // ties resolve to lowest index
        for (int i = 0; i < N; i++) v[i*W +: W] = 16'h1000;
        v[3*W +: W] = 16'h8000;
        v[7*W +: W] = 16'h8000;
        step(); issue(v);
        steps(16);
        chk("ties_argmax", argmax, 3);
        steps(2);

        // reset mid-stream
        step(); c0 = cyc; issue(rand_vec(65535));
        steps(10);
        chk("mid_tuser_before", m_tuser, 5);
        areset = 1'b1;
        step();
        chk("mid_tvalid", m_tvalid, 0);
        chk("mid_tlast", m_tlast, 0);
        chk("mid_tdata", m_tdata, 0);
        areset = 1'b0;
        steps(2);
        step(); issue(rand_vec(65535));
        steps(5);
        chk("mid_fresh_tvalid", m_tvalid, 1);
        chk("mid_fresh_tuser", m_tuser, 0);
        steps(12);

        // randomized traffic with occasional resets and heavy ties
        rdy_mode = 2;
        for (int k = 0; k < 600; k++) begin
            step();
            if ($urandom_range(0, 199) == 0) areset = 1'b1;
            else areset = 1'b0;
            if (!areset && $urandom_range(0, 5) == 0)
                issue(($urandom_range(0, 1) == 0) ? rand_vec(3) : rand_vec(65535));
        end
        areset = 1'b0;
        rdy_mode = 0;
        steps(25);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
